// File: rtl/cpu19_pkg.sv
// cpu19_pkg: shared widths, opcodes, redirect kinds and fetch state encoding for cpu19.
package cpu19_pkg;
    localparam int INSTR_W = 19;
    localparam logic [4:0] OP_ADD     = 5'b00000;
    localparam logic [4:0] OP_JMP     = 5'b01010;
    localparam logic [4:0] OP_CALL    = 5'b01101;
    localparam logic [4:0] OP_RET     = 5'b01110;
    localparam logic [4:0] OP_DECRYPT = 5'b10001;
    localparam logic [1:0] RK_JUMP = 2'b00;
    localparam logic [1:0] RK_CALL = 2'b01;
    localparam logic [1:0] RK_RET  = 2'b10;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FETCH   = 2'd1;
    localparam logic [1:0] ST_PRESENT = 2'd2;
    localparam logic [1:0] ST_HALT    = 2'd3;
endpackage

// File: rtl/cpu19_ret_stack.sv
// cpu19_ret_stack: return-address LIFO; push on full and pop on empty are ignored.
module cpu19_ret_stack #(
    parameter int DEPTH = 8,
    parameter int W = 8,
    localparam int SPW = $clog2(DEPTH + 1),
    localparam int IW = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  logic           pop,
    input  logic [W-1:0]   data,
    output logic [W-1:0]   top,
    output logic [SPW-1:0] sp,
    output logic           full,
    output logic           empty
);
    logic [W-1:0] mem [DEPTH];
    always_comb begin
        top = mem[IW'(sp - 1'b1)];
        full = sp == SPW'(DEPTH);
        empty = sp == '0;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) sp <= '0;
        else if (push && !full) sp <= sp + 1'b1;
        else if (pop && !empty) sp <= sp - 1'b1;
    always_ff @(posedge clk)
        if (push && !full) mem[IW'(sp)] <= data;
endmodule

// File: rtl/cpu19_fetch.sv
// cpu19_fetch: instruction fetch stage with program memory, pc, redirects and return stack.
module cpu19_fetch #(
    parameter int ADDR_W = 8,
    parameter int INSTR_W = cpu19_pkg::INSTR_W,
    parameter int STACK_DEPTH = 8,
    localparam int SP_W = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redir_valid,
    input  logic [1:0]         redir_kind,
    input  logic [13:0]        redir_target,
    output logic [SP_W-1:0]    sp,
    output logic               stack_fault,
    output logic               halted
);
    import cpu19_pkg::*;
    logic [INSTR_W-1:0] mem [2**ADDR_W];
    logic [1:0] state;
    logic [ADDR_W-1:0] pc, pc_inc, next_pc, top;
    logic accept, redir, is_call, is_ret, full, empty, fault, read;
    logic unused_target;
    assign unused_target = ^redir_target[13:ADDR_W];
    always_comb begin
        accept = state == ST_PRESENT && instr_ready;
        redir = accept && redir_valid;
        is_call = redir_kind == RK_CALL;
        is_ret = redir_kind == RK_RET;
        fault = redir && (is_call ? full : is_ret && empty);
        pc_inc = pc + 1'b1;
        next_pc = !accept ? pc : !redir_valid ? pc_inc : is_ret ? top : redir_target[ADDR_W-1:0];
        read = run && (state == ST_FETCH || (accept && !redir_valid));
    end
    cpu19_ret_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W)) u_stack (
        .clk(clk), .rst(rst), .push(redir && is_call), .pop(redir && is_ret),
        .data(pc_inc), .top(top), .sp(sp), .full(full), .empty(empty)
    );
    // A faulting call/return freezes pc and stack; only reset leaves HALT.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= ST_IDLE;
            pc <= '0;
            instr <= '0;
            instr_pc <= '0;
        end else if (fault) state <= ST_HALT;
        else if (state != ST_HALT) begin
            pc <= next_pc;
            state <= !run ? ST_IDLE : (state == ST_IDLE || redir) ? ST_FETCH : ST_PRESENT;
            if (read) begin
                instr <= mem[next_pc];
                instr_pc <= next_pc;
            end
        end
    always_ff @(posedge clk)
        if (prog_we && !run && state != ST_HALT) mem[prog_addr] <= prog_data;
    assign instr_valid = state == ST_PRESENT;
    assign halted = state == ST_HALT;
    assign stack_fault = halted;
endmodule

// File: tb/tb_cpu19_fetch.sv
// tb_cpu19_fetch: directed and random fetch traffic checked against a transaction-level model.
module tb_cpu19_fetch;
    logic clk = 0, rst = 0, run = 0, prog_we = 0, instr_ready = 0, redir_valid = 0;
    logic [7:0] prog_addr = 0, instr_pc;
    logic [18:0] prog_data = 0, instr;
    logic [1:0] redir_kind = 0;
    logic [13:0] redir_target = 0;
    logic [3:0] sp;
    logic instr_valid, stack_fault, halted;
    int total = 0, bad = 0;
    logic [18:0] m_mem [256];
    logic [7:0] m_pc, stk [$];
    bit m_valid, m_halt;
    int pend;

    cpu19_fetch dut (
        .clk(clk), .rst(rst), .run(run), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .redir_valid(redir_valid), .redir_kind(redir_kind),
        .redir_target(redir_target), .sp(sp), .stack_fault(stack_fault), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("valid", instr_valid, m_valid);
        chk("sp", sp, stk.size());
        chk("halted", halted, m_halt);
        chk("fault", stack_fault, m_halt);
        if (m_valid) begin
            chk("pc", instr_pc, m_pc);
            chk("instr", instr, m_mem[m_pc]);
        end
    endtask

    // pend counts clock edges until the next instruction shows up; -1 means fetch is idle.
    task automatic tick();
        bit acc;
        if (m_halt) return;
        acc = m_valid && instr_ready;
        if (prog_we && !run) m_mem[prog_addr] = prog_data;
        if (acc && redir_valid) begin
            if ((redir_kind == 2'd1 && stk.size() == 8) || (redir_kind == 2'd2 && stk.size() == 0)) begin
                m_halt = 1;
                m_valid = 0;
                return;
            end
            if (redir_kind == 2'd1) begin
                stk.push_back(m_pc + 8'd1);
                m_pc = redir_target[7:0];
            end else if (redir_kind == 2'd2) m_pc = stk.pop_back();
            else m_pc = redir_target[7:0];
        end else if (acc) m_pc = m_pc + 8'd1;
        if (!run) begin
            m_valid = 0;
            pend = -1;
        end else if (pend == -1) pend = 1;
        else if (acc && redir_valid) begin
            m_valid = 0;
            pend = 1;
        end else if (!m_valid) begin
            pend--;
            if (pend == 0) m_valid = 1;
        end
    endtask

    task automatic cyc(input bit r, input bit rd, input bit rv, input logic [1:0] k, input logic [13:0] t);
        run = r;
        instr_ready = rd;
        redir_valid = rv;
        redir_kind = k;
        redir_target = t;
        tick();
        @(negedge clk);
        check_all();
        prog_we = 0;
    endtask

    task automatic go(input bit rv, input logic [1:0] k, input logic [13:0] t);
        for (int i = 0; i < 4 && !m_valid; i++) cyc(1, 0, 0, 0, 0);
        cyc(1, 1, rv, k, t);
    endtask

    task automatic reset_dut();
        rst = 0;
        #1;
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_sp", sp, 0);
        chk("rst_fault", stack_fault, 0);
        chk("rst_halted", halted, 0);
        run = 0;
        instr_ready = 0;
        redir_valid = 0;
        prog_we = 0;
        m_pc = 0;
        m_valid = 0;
        m_halt = 0;
        pend = -1;
        stk.delete();
        #1 rst = 1;
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [18:0] init [4] = '{19'h00012, 19'h08345, 19'h10678, 19'h189AB};
        bit r = 1;
        logic [1:0] k;
        @(negedge clk);
        reset_dut();
        for (int a = 0; a < 256; a++) begin
            prog_we = 1;
            prog_addr = 8'(a);
            prog_data = a < 4 ? init[a] : 19'($urandom);
            cyc(0, 0, 0, 0, 0);
        end
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        repeat (5) cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 1, 2'd3, 14'd1);
        go(1, 2'd0, 14'h3F12);
        go(1, 2'd0, 14'd4);
        go(1, 2'd1, 14'd50);
        go(0, 0, 0);
        go(1, 2'd1, 14'd60);
        go(0, 0, 0);
        go(1, 2'd2, 0);
        go(1, 2'd2, 0);
        go(0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);
        go(0, 0, 0);
        for (int i = 0; i < 4 && !m_valid; i++) cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        go(1, 2'd0, 14'd254);
        repeat (4) go(0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 40 == 0) r = !r;
            k = 2'($urandom);
            if (k == 2'd1 && stk.size() >= 8) k = 2'd0;
            if (k == 2'd2 && stk.size() == 0) k = 2'd0;
            prog_we = $urandom % 10 == 0;
            prog_addr = 8'($urandom);
            prog_data = 19'($urandom);
            cyc(r, $urandom % 3 != 0, $urandom % 5 == 0, k, 14'($urandom));
        end
        reset_dut();
        for (int i = 0; i < 9; i++) go(1, 2'd1, 14'(10 + 3 * i));
        prog_we = 1;
        prog_addr = 0;
        prog_data = ~m_mem[0];
        repeat (3) cyc(1, 1, 1, 2'd0, 14'd5);
        prog_we = 1;
        repeat (2) cyc(0, 0, 0, 0, 0);
        reset_dut();
        go(1, 2'd2, 0);
        repeat (3) cyc(1, 1, 1, 2'd2, 0);
        reset_dut();
        go(1, 2'd1, 14'd20);
        go(1, 2'd1, 14'd30);
        go(1, 2'd1, 14'd40);
        go(1, 2'd0, 14'd7);
        repeat (3) cyc(1, 0, 0, 0, 0);
        reset_dut();
        repeat (3) cyc(1, 1, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu19_fetch.md
Name: cpu19_fetch

Overview:
- Instruction fetch stage directly upstream of cpu19. Holds the program in an internal synchronous ROM/RAM and maintains the program counter.
- Presents one 19-bit instruction per cycle on a valid/ready handshake.
- Applies jump, branch, call and return redirects reported by cpu19. Owns the hardware return-address stack.

Parameters:
- ADDR_W, 8, PC and program-memory address width; memory holds 2^ADDR_W words.
- INSTR_W, 19, instruction width.
- STACK_DEPTH, 8, return-stack entries.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  1 = fetch enabled; 0 = fetch paused and program load allowed.
- prog_we  in  1  program-memory write strobe; honoured only while run=0.
- prog_addr  in  ADDR_W  program write address.
- prog_data  in  INSTR_W  program write data.
- instr  out  INSTR_W  instruction to cpu19.
- instr_pc  out  ADDR_W  address of instr.
- instr_valid  out  1  instr/instr_pc valid.
- instr_ready  in  1  cpu19 accepts instr this cycle.
- redir_valid  in  1  accepted instruction redirects control flow.
- redir_kind  in  2  00 jump/taken branch, 01 call, 10 return, 11 treated as jump.
- redir_target  in  14  target address; low ADDR_W bits used.
- sp  out  clog2(STACK_DEPTH+1)  return-stack occupancy.
- stack_fault  out  1  sticky overflow/underflow flag.
- halted  out  1  fetch stopped by fault.

Behaviour:
- Reset (rst=0, async): pc=0, instr=0, instr_pc=0, instr_valid=0, sp=0, stack_fault=0, halted=0, state=IDLE. Memory contents are not reset.
- States:
  - IDLE: run=0 or just out of reset.
  - FETCH: read issued, no valid data.
  - PRESENT: instr_valid=1.
  - HALT: fault.
- IDLE -> FETCH when run=1. Memory reads pc and registers the data. FETCH -> PRESENT next cycle. Read latency is 1 cycle, so the first instr_valid comes 2 cycles after run rises.
- PRESENT, no accept (instr_ready=0): instr, instr_pc and instr_valid held stable. Stall has no limit.
- PRESENT, accept with redir_valid=0: pc+1 is read the same cycle, the next instruction is valid the following cycle (1 instr/cycle sustained), and pc wraps 2^ADDR_W-1 -> 0.
- Redirect is qualified by accept. redir_valid without instr_valid&instr_ready is ignored.
- Accept with redir_valid=1:
  - Next instr_valid=0 (one bubble cycle, state FETCH).
  - pc = target, per kind:
    - jump: target.
    - call: push instr_pc+1, then target.
    - return: pop top of stack.
  - Target instruction is valid 2 cycles after the redirecting accept.
- Stack:
  - Call with sp==STACK_DEPTH, or return with sp==0, sets stack_fault=1 and halted=1 and enters HALT.
  - The stack and pc are unchanged by the faulting op.
  - HALT: instr_valid=0, ignores run and redirects; only reset exits.
- run falls: next cycle instr_valid=0, state IDLE, pc holds the address of the unaccepted instruction, so nothing is lost. An instruction accepted in the same cycle as run falls still advances pc.
- prog_we while run=1 or halted=1: ignored.
- Reset asserted mid-operation clears all state immediately, including a stack push in flight.

Decomposition:
- Shared package cpu19_pkg:
  - INSTR_W.
  - Opcode constants (ADD 00000 through DECRYPT 10001; JMP 01010, CALL 01101, RET 01110).
  - redir_kind encodings RK_JUMP/RK_CALL/RK_RET.
  - Fetch state encoding.
- One sub-module: cpu19_ret_stack (LIFO, push/pop/full/empty, STACK_DEPTH×ADDR_W).

Test Plan:
- Load mem[0..3]=0x00012, 0x08345, 0x10678, 0x189AB with run=0, then run=1, instr_ready=1 -> instr_valid rises 2 cycles after run; instr_pc 0,1,2,3 on consecutive cycles with matching data.
- Stall: instr_ready=0 for 5 cycles at pc=2 -> instr=0x10678 and instr_pc=2 held stable; resume -> pc=3 next cycle, no skip or duplicate.
- Jump: accept at pc=1 with redir_valid=1, kind=00, target=18 -> one bubble, then instr_pc=18; pc=2 never presented.
- Nested call/return: call at pc=4 to 50, call at pc=51 to 60, return at 61, return at 52 -> sp 1,2,1,0; returns land at pc=52 then pc=5.
- Faults: 9 calls with STACK_DEPTH=8 -> stack_fault=1 and halted=1 after the 9th, sp=8. Separately, a return at sp=0 -> fault, instr_valid stays 0 with run=1.
- Reset mid-stall at pc=7 with sp=3 -> all outputs return to reset values asynchronously; refetch starts at pc=0.
